// File: rtl/bounce_gen.sv
// rtl/bounce_gen.sv - contact-bounce emulator: chatters b 2n times around a commanded level, then settles.
// Optional BOUNCE_GEN_LFSR_EN randomizes each segment length from a 16-bit LFSR.
module bounce_gen #(
  parameter int          SETTLE_CYC  = 16,
  parameter int          CNT_W       = 8,
  parameter bit          RESET_LEVEL = 1'b0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_level,
  input  logic [2:0]       bounce_cnt,
  input  logic [CNT_W-1:0] interval,
  output logic             b,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BOUNCE = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  // Hold timer is one bit wider than interval so the LFSR range 1..iv+1 fits.
  localparam int TW = CNT_W + 1;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC);

  logic [1:0]       state_q, state_d;
  logic             b_q, b_d;
  logic [CNT_W-1:0] iv_q, iv_d;
  logic [3:0]       seg_q, seg_d;
  logic [TW-1:0]    hold_q, hold_d;
  logic [SW-1:0]    set_q, set_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] iv_sel;
  logic [TW-1:0]    hold_load;

  assign iv_sel = (state_q == ST_IDLE) ? interval : iv_q;

`ifdef BOUNCE_GEN_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign hold_load = TW'(lfsr_q[CNT_W-1:0] & iv_sel) + TW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end
`else
  assign hold_load = (iv_sel == '0) ? TW'(1) : {1'b0, iv_sel};
`endif

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    iv_d    = iv_q;
    seg_d   = seg_q;
    hold_d  = hold_q;
    set_d   = set_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          b_d    = cmd_level;
          iv_d   = interval;
          seg_d  = {bounce_cnt, 1'b0};
          hold_d = hold_load;
          if (bounce_cnt == 3'd0) begin
            state_d = ST_SETTLE;
            set_d   = SETTLE_LD;
          end else begin
            state_d = ST_BOUNCE;
          end
        end
      end
      ST_BOUNCE: begin
        // An even number of toggles always leaves b back at the target.
        if (hold_q <= TW'(1)) begin
          b_d    = ~b_q;
          seg_d  = seg_q - 4'd1;
          hold_d = hold_load;
          if (seg_q <= 4'd1) begin
            state_d = ST_SETTLE;
            set_d   = SETTLE_LD;
          end
        end else begin
          hold_d = hold_q - TW'(1);
        end
      end
      ST_SETTLE: begin
        if (set_q <= SW'(1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          set_d = set_q - SW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      b_q     <= RESET_LEVEL;
      iv_q    <= '0;
      seg_q   <= '0;
      hold_q  <= '0;
      set_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      iv_q    <= iv_d;
      seg_q   <= seg_d;
      hold_q  <= hold_d;
      set_q   <= set_d;
      done_q  <= done_d;
    end
  end

  assign b         = b_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign cmd_ready = (state_q == ST_IDLE);

endmodule
